// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared constants and width helpers for the fixed-point arithmetic units
package fxp_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // One extra integer bit so negating the most negative operand stays exact
    function automatic int align_iw(input int iw_a, input int iw_b);
        return max_int(iw_a, iw_b) + 1;
    endfunction

    function automatic int align_fw(input int fw_a, input int fw_b);
        return max_int(fw_a, fw_b);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - combinational fraction reduction, range check and saturate/wrap
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int IN_IW = 7,
    parameter int IN_FW = 14,
    parameter int O_IW  = 6,
    parameter int O_FW  = 12
) (
    input  logic [IN_IW+IN_FW-1:0] din,
    input  logic [1:0]             rnd_mode,
    input  logic                   sat_en,
    output logic [O_IW+O_FW-1:0]   dout,
    output logic                   ovf,
    output logic                   unf
);

    localparam int IN_W = IN_IW + IN_FW;
    localparam int OW   = O_IW + O_FW;
    localparam int D    = (IN_FW > O_FW) ? IN_FW - O_FW : 0;
    localparam int PAD  = (O_FW > IN_FW) ? O_FW - IN_FW : 0;
    localparam int RW   = IN_W - D + PAD + 1;
    localparam int CW   = max_int(RW, OW) + 1;

    logic signed [RW-1:0] q;

    generate
        if (D > 0) begin : g_round
            localparam logic [IN_W-1:0] ONE_W     = 1;
            localparam logic [IN_W-1:0] REST_MASK = (ONE_W << (D - 1)) - ONE_W;

            logic signed [RW-1:0] q_floor;
            logic half;
            logic rest;
            logic inc;

            // Arithmetic shift of a two's-complement value is a floor
            assign q_floor = {din[IN_W-1], din[IN_W-1:D]};
            assign half    = din[D-1];
            assign rest    = |(din & REST_MASK);

            always_comb begin
                inc = 1'b0;
                case (rnd_mode)
                    RND_TRUNC:     inc = 1'b0;
                    RND_HALF_UP:   inc = half;
                    RND_HALF_EVEN: inc = half & (rest | q_floor[0]);
                    default:       inc = 1'b0;
                endcase
            end

            assign q = q_floor + {{(RW-1){1'b0}}, inc};
        end else begin : g_pad
            logic signed [RW-1:0] din_ext;
            assign din_ext = RW'($signed(din));
            assign q       = din_ext <<< PAD;
        end
    endgenerate

    localparam logic signed [CW-1:0] ONE_C = 1;
    localparam logic signed [CW-1:0] MAXV  = (ONE_C <<< (OW - 1)) - ONE_C;
    localparam logic signed [CW-1:0] MINV  = -(ONE_C <<< (OW - 1));

    logic signed [CW-1:0] qe;
    assign qe = CW'(q);

    always_comb begin
        ovf  = (qe > MAXV);
        unf  = (qe < MINV);
        dout = qe[OW-1:0];
        if (sat_en && ovf) dout = MAXV[OW-1:0];
        if (sat_en && unf) dout = MINV[OW-1:0];
    end

endmodule

// File: rtl/fxp_addsub_pipe.sv
// rtl/fxp_addsub_pipe.sv - three-stage signed fixed-point add/subtract with valid/ready streams
module fxp_addsub_pipe
    import fxp_pkg::*;
#(
    parameter int IW_A = 5,
    parameter int FW_A = 14,
    parameter int IW_B = 5,
    parameter int FW_B = 14,
    parameter int O_IW = 6,
    parameter int O_FW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW_A+FW_A-1:0] a,
    input  logic [IW_B+FW_B-1:0] b,
    input  logic                 sub,
    input  logic [1:0]           rnd_mode,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [O_IW+O_FW-1:0] sum,
    output logic                 ovf,
    output logic                 unf,
    output logic                 ovf_sticky,
    output logic                 unf_sticky,
    input  logic                 flag_clr
);

    localparam int IW = align_iw(IW_A, IW_B);
    localparam int FW = align_fw(FW_A, FW_B);
    localparam int AW = IW + FW;
    localparam int SW = AW + 1;
    localparam int OW = O_IW + O_FW;

    logic signed [AW-1:0] a_al, b_al, b_op;
    assign a_al = AW'($signed(a)) <<< (FW - FW_A);
    assign b_al = AW'($signed(b)) <<< (FW - FW_B);
    assign b_op = sub ? -b_al : b_al;

    logic                 s1_valid, s2_valid;
    logic signed [AW-1:0] s1_a, s1_b;
    logic [1:0]           s1_rnd, s2_rnd;
    logic                 s1_sat, s2_sat;
    logic signed [SW-1:0] s2_sum;

    logic ld1, ld2, ld3;
    assign ld3      = ~out_valid | out_ready;
    assign ld2      = ~s2_valid | ld3;
    assign ld1      = ~s1_valid | ld2;
    assign in_ready = ld1;

    logic [OW-1:0] rs_sum;
    logic          rs_ovf, rs_unf;

    fxp_round_sat #(
        .IN_IW (IW + 1),
        .IN_FW (FW),
        .O_IW  (O_IW),
        .O_FW  (O_FW)
    ) u_round_sat (
        .din      (s2_sum),
        .rnd_mode (s2_rnd),
        .sat_en   (s2_sat),
        .dout     (rs_sum),
        .ovf      (rs_ovf),
        .unf      (rs_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            sum        <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            if (ld1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= a_al;
                    s1_b   <= b_op;
                    s1_rnd <= rnd_mode;
                    s1_sat <= sat_en;
                end
            end
            if (ld2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sum <= SW'(s1_a) + SW'(s1_b);
                    s2_rnd <= s1_rnd;
                    s2_sat <= s1_sat;
                end
            end
            if (ld3) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    sum <= rs_sum;
                    ovf <= rs_ovf;
                    unf <= rs_unf;
                end
            end
            // Clear takes priority over a flag raised by a beat leaving this cycle
            if (flag_clr) begin
                ovf_sticky <= 1'b0;
                unf_sticky <= 1'b0;
            end else if (out_valid && out_ready) begin
                if (ovf) ovf_sticky <= 1'b1;
                if (unf) unf_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// tb/tb_fxp_addsub_pipe.sv - scoreboard bench for the pipelined fixed-point add/subtract unit
module tb_fxp_addsub_pipe;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, sat_en = 1'b0;
    logic        out_ready = 1'b1, flag_clr = 1'b0;
    logic [1:0]  rnd_mode = 2'd0;
    logic [18:0] a = '0, b = '0;

    logic        in_ready, out_valid, ovf, unf, ovf_sticky, unf_sticky;
    logic [17:0] sum;
    logic        in_ready5, out_valid5, ovf5, unf5, ovf_sticky5, unf_sticky5;
    logic [16:0] sum5;

    always #5 clk = ~clk;

    fxp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf), .unf(unf),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .flag_clr(flag_clr)
    );

    fxp_addsub_pipe #(.O_IW(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .a(a), .b(b), .sub(sub), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(out_valid5), .out_ready(out_ready), .sum(sum5), .ovf(ovf5), .unf(unf5),
        .ovf_sticky(ovf_sticky5), .unf_sticky(unf_sticky5), .flag_clr(flag_clr)
    );

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic        unf;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q6[$];
    exp_t q5[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_del = 0;
    bit   lat_mode = 1'b0, st_o = 1'b0, st_u = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: operands are Q.14, result Q.12 with ow total bits
    function automatic exp_t model(input logic [18:0] av, input logic [18:0] bv, input logic s,
                                   input logic [1:0] rm, input logic st, input int ow);
        exp_t   e;
        longint x, y, t, f, r, mx, mn;
        x  = longint'($signed(av));
        y  = longint'($signed(bv));
        t  = s ? x - y : x + y;
        f  = t >>> 2;
        r  = t - f * 4;
        if (rm == 2'd1 && r >= 2) f = f + 1;
        else if (rm == 2'd2 && (r > 2 || (r == 2 && f[0]))) f = f + 1;
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        e.ovf = (f > mx);
        e.unf = (f < mn);
        if (st && e.ovf) f = mx;
        if (st && e.unf) f = mn;
        e.sum = 32'(f & ((longint'(1) << ow) - 1));
        e.cyc = cyc;
        e.lat = lat_mode;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        bit   so, su;
        @(negedge clk);
        chk("ovf_sticky", 32'(ovf_sticky), 32'(st_o));
        chk("unf_sticky", 32'(unf_sticky), 32'(st_u));
        so = 1'b0;
        su = 1'b0;
        if (out_valid && out_ready) begin
            n_del++;
            if (q6.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
                e = q6.pop_front();
                chk("sum", 32'(sum), e.sum);
                chk("flags", {30'd0, ovf, unf}, {30'd0, e.ovf, e.unf});
                if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
                so = e.ovf;
                su = e.unf;
            end
        end
        if (out_valid5 && out_ready) begin
            if (q5.size() == 0) chk("spurious_out5", 32'd1, 32'd0);
            else begin
                e = q5.pop_front();
                chk("sum5", 32'(sum5), e.sum);
                chk("flags5", {30'd0, ovf5, unf5}, {30'd0, e.ovf, e.unf});
            end
        end
        if (in_valid && in_ready)  q6.push_back(model(a, b, sub, rnd_mode, sat_en, 18));
        if (in_valid && in_ready5) q5.push_back(model(a, b, sub, rnd_mode, sat_en, 17));
        if (flag_clr) begin
            st_o = 1'b0;
            st_u = 1'b0;
        end else begin
            st_o = st_o | so;
            st_u = st_u | su;
        end
        if (rst) begin
            q6.delete();
            q5.delete();
            st_o = 1'b0;
            st_u = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [18:0] av, input logic [18:0] bv, input logic s,
                        input logic [1:0] rm, input logic st);
        bit got;
        got      = 1'b0;
        a        = av;
        b        = bv;
        sub      = s;
        rnd_mode = rm;
        sat_en   = st;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            got = in_ready;
            tick();
            if (got) break;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q6.size() == 0 && q5.size() == 0) break;
            tick();
        end
        chk("drain", 32'(q6.size() + q5.size()), 32'd0);
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk("out_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int d0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);

        // 1.5 + 2.25 with latency tracking
        lat_mode = 1'b1;
        send(19'h06000, 19'h09000, 1'b0, 2'd0, 1'b0);
        lat_mode = 1'b0;
        drain();

        // Near-max operands: trunc, half-up saturate, half-up wrap
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd0, 1'b0);
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd1, 1'b1);
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd1, 1'b0);
        drain();
        chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);

        // -10 + -10 underflows the narrower instance
        send(19'h58000, 19'h58000, 1'b0, 2'd0, 1'b1);
        // -16 - (16 - 2^-14) floors onto the exact minimum
        send(19'h40000, 19'h3FFFF, 1'b1, 2'd0, 1'b0);
        // Ties and mode 3
        send(19'h00006, 19'h00000, 1'b0, 2'd2, 1'b0);
        send(19'h0000A, 19'h00000, 1'b0, 2'd2, 1'b0);
        send(19'h0000A, 19'h00000, 1'b0, 2'd1, 1'b0);
        send(19'h7FFFE, 19'h00000, 1'b0, 2'd1, 1'b0);
        send(19'h7FFFA, 19'h00000, 1'b0, 2'd2, 1'b0);
        send(19'h00007, 19'h00002, 1'b1, 2'd3, 1'b0);
        drain();

        for (int i = 0; i < 30; i++)
            send(19'($urandom), 19'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        drain();

        // Backpressure: three beats fill the pipe, the fourth waits
        out_ready = 1'b0;
        send(19'h04000, 19'h00000, 1'b0, 2'd0, 1'b0);
        send(19'h08000, 19'h00000, 1'b0, 2'd0, 1'b0);
        send(19'h0C000, 19'h00000, 1'b0, 2'd0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        a        = 19'h10000;
        in_valid = 1'b1;
        tick();
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        chk("bp_out_held", 32'(sum), 32'h01000);
        out_ready = 1'b1;
        d0 = n_del;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_no_gap", 32'(n_del - d0), 32'd4);
        drain();

        // Reset with beats in flight and the sticky flag set
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd1, 1'b1);
        drain();
        out_ready = 1'b0;
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd1, 1'b1);
        send(19'h01000, 19'h02000, 1'b0, 2'd0, 1'b0);
        send(19'h03000, 19'h02000, 1'b1, 2'd0, 1'b0);
        chk("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) tick();

        // Clear coincident with an overflowing delivery
        out_ready = 1'b0;
        send(19'h3FFFF, 19'h3FFFF, 1'b0, 2'd1, 1'b1);
        wait_out();
        flag_clr  = 1'b1;
        out_ready = 1'b1;
        tick();
        flag_clr = 1'b0;
        tick();
        chk("clr_wins", 32'(ovf_sticky), 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
